// File: rtl/synchronizer_nff_filt.sv
// synchronizer_nff_filt: multi-channel N-flop level synchronizer.
// Each channel has an N-stage sync chain, an optional stability filter and
// single-cycle rise/fall event outputs.
// Optional feature macro: SYNC_EDGE_CNT_EN adds saturating per-channel
// rising-edge counters (cnt_clr_i, rise_cnt_o).
// Only single-bit levels or Gray-coded buses may pass through; channels
// carry no mutual coherency guarantee.
module synchronizer_nff_filt #(
    parameter int unsigned          CHANNELS      = 4,
    parameter int unsigned          STAGES        = 2,
    parameter int unsigned          FILTER_CYCLES = 0,
    parameter logic [CHANNELS-1:0]  RESET_VALUE   = '0,
    parameter int unsigned          CNT_WIDTH     = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [CHANNELS-1:0]           async_i,
    output logic [CHANNELS-1:0]           sync_o,
    output logic [CHANNELS-1:0]           rise_o,
    output logic [CHANNELS-1:0]           fall_o
`ifdef SYNC_EDGE_CNT_EN
    ,
    input  logic                          cnt_clr_i,
    output logic [CHANNELS*CNT_WIDTH-1:0] rise_cnt_o
`endif
);

    if (STAGES < 2) begin : g_stages_chk
        $error("synchronizer_nff_filt: STAGES must be >= 2");
    end
    if (CHANNELS < 1) begin : g_chan_chk
        $error("synchronizer_nff_filt: CHANNELS must be >= 1");
    end
    if (CNT_WIDTH < 1) begin : g_cntw_chk
        $error("synchronizer_nff_filt: CNT_WIDTH must be >= 1");
    end

    logic [CHANNELS-1:0] chain_q [STAGES];
    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] hist_q;

    // Sync chain: stage 0 samples the asynchronous inputs, later stages shift.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                chain_q[k] <= RESET_VALUE;
            end
        end else begin
            chain_q[0] <= async_i;
            for (int unsigned k = 1; k < STAGES; k++) begin
                chain_q[k] <= chain_q[k-1];
            end
        end
    end

    assign raw = chain_q[STAGES-1];

    if (FILTER_CYCLES == 0) begin : g_bypass
        assign sync_o = raw;
    end else begin : g_filter
        localparam int unsigned     FCW   = $clog2(FILTER_CYCLES + 1);
        localparam logic [FCW-1:0]  FLAST = FCW'(FILTER_CYCLES - 1);

        logic [FCW-1:0]      fcnt_q [CHANNELS];
        logic [CHANNELS-1:0] filt_q;

        // Stability filter: output follows raw only after FILTER_CYCLES
        // consecutive cycles of disagreement; any return to the current
        // output level restarts the count.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                filt_q <= RESET_VALUE;
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    fcnt_q[c] <= '0;
                end
            end else begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    if (raw[c] == filt_q[c]) begin
                        fcnt_q[c] <= '0;
                    end else if (fcnt_q[c] == FLAST) begin
                        filt_q[c] <= raw[c];
                        fcnt_q[c] <= '0;
                    end else begin
                        fcnt_q[c] <= fcnt_q[c] + 1'b1;
                    end
                end
            end
        end

        assign sync_o = filt_q;
    end

    // Edge history: previous cycle's sync_o, reset to the same value so
    // reset release never produces a spurious edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= RESET_VALUE;
        end else begin
            hist_q <= sync_o;
        end
    end

    // Edge pulses; forced low while reset is held so the first cycle of
    // reset cannot expose pre-reset register contents.
    always_comb begin
        rise_o = sync_o & ~hist_q & {CHANNELS{~rst_i}};
        fall_o = ~sync_o & hist_q & {CHANNELS{~rst_i}};
    end

`ifdef SYNC_EDGE_CNT_EN
    logic [CNT_WIDTH-1:0] ecnt_q [CHANNELS];

    // Saturating rising-edge counters; clear wins over a coincident rise.
    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                ecnt_q[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (rise_o[c] && (ecnt_q[c] != '1)) begin
                    ecnt_q[c] <= ecnt_q[c] + 1'b1;
                end
            end
        end
    end

    // Pack the per-channel counters onto the flat output bus.
    always_comb begin
        rise_cnt_o = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            rise_cnt_o[c*CNT_WIDTH +: CNT_WIDTH] = ecnt_q[c];
        end
    end
`endif

endmodule

// File: tb/tb_synchronizer_nff_filt.sv
// Testbench for synchronizer_nff_filt: two instances (F=0 with STAGES=3 and
// RESET_VALUE=4'b1010; F=4 with STAGES=2) checked every cycle against a
// queue-based scoreboard whose entries emerge STAGES edges after being pushed.
module tb_synchronizer_nff_filt;

    localparam logic [3:0] RV0 = 4'b1010;
    localparam int unsigned F1 = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] async_i = '0;
    logic       cnt_clr_i = 1'b0;

    logic [3:0] sync0, rise0, fall0;
    logic [3:0] sync1, rise1, fall1;
    logic [7:0] cnt0, cnt1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // scoreboard state
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic [3:0] s0, p0, s1, p1;
    int unsigned fc1 [4];
    logic [1:0] ec0 [4];
    logic [1:0] ec1 [4];

    // DUT pulse tallies for window checks
    int unsigned f0_fall [4];
    int unsigned f0_rise [4];
    int unsigned f4_rise [4];
    int unsigned f4_fall [4];

    always #5 clk_i = ~clk_i;

    synchronizer_nff_filt #(
        .CHANNELS(4), .STAGES(3), .FILTER_CYCLES(0), .RESET_VALUE(RV0), .CNT_WIDTH(2)
    ) u_f0 (
        .clk_i(clk_i), .rst_i(rst_i), .async_i(async_i),
        .sync_o(sync0), .rise_o(rise0), .fall_o(fall0)
`ifdef SYNC_EDGE_CNT_EN
        , .cnt_clr_i(cnt_clr_i), .rise_cnt_o(cnt0)
`endif
    );

    synchronizer_nff_filt #(
        .CHANNELS(4), .STAGES(2), .FILTER_CYCLES(F1), .RESET_VALUE(4'b0000), .CNT_WIDTH(2)
    ) u_f4 (
        .clk_i(clk_i), .rst_i(rst_i), .async_i(async_i),
        .sync_o(sync1), .rise_o(rise1), .fall_o(fall1)
`ifdef SYNC_EDGE_CNT_EN
        , .cnt_clr_i(cnt_clr_i), .rise_cnt_o(cnt1)
`endif
    );

`ifndef SYNC_EDGE_CNT_EN
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_tallies();
        for (int i = 0; i < 4; i++) begin
            f0_fall[i] = 0; f0_rise[i] = 0; f4_rise[i] = 0; f4_fall[i] = 0;
        end
    endtask

    // One clock: update scoreboard with pre-edge inputs, then compare #1 later.
    task automatic step();
        logic [3:0] a, raw_old, rz0, rz1, er0, ef0, er1, ef1;
        logic       r, c;
        a = async_i; r = rst_i; c = cnt_clr_i;
        rz0 = s0 & ~p0;
        rz1 = s1 & ~p1;
        @(posedge clk_i);
        if (r) begin
            q0 = {}; repeat (3) q0.push_back(RV0);
            q1 = {}; repeat (2) q1.push_back(4'b0000);
            s0 = RV0; p0 = RV0; s1 = '0; p1 = '0;
            for (int i = 0; i < 4; i++) begin
                fc1[i] = 0; ec0[i] = '0; ec1[i] = '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (c) begin
                    ec0[i] = '0; ec1[i] = '0;
                end else begin
                    if (rz0[i] && ec0[i] != 2'd3) ec0[i] = ec0[i] + 2'd1;
                    if (rz1[i] && ec1[i] != 2'd3) ec1[i] = ec1[i] + 2'd1;
                end
            end
            p0 = s0;
            q0.push_back(a);
            void'(q0.pop_front());
            s0 = q0[0];
            p1 = s1;
            raw_old = q1[0];
            q1.push_back(a);
            void'(q1.pop_front());
            for (int i = 0; i < 4; i++) begin
                if (raw_old[i] == s1[i]) begin
                    fc1[i] = 0;
                end else begin
                    fc1[i]++;
                    if (fc1[i] == F1) begin
                        s1[i] = raw_old[i];
                        fc1[i] = 0;
                    end
                end
            end
        end
        #1;
        er0 = rst_i ? 4'b0 : (s0 & ~p0);
        ef0 = rst_i ? 4'b0 : (~s0 & p0);
        er1 = rst_i ? 4'b0 : (s1 & ~p1);
        ef1 = rst_i ? 4'b0 : (~s1 & p1);
        check_eq("f0_sync", 32'(sync0), 32'(s0));
        check_eq("f0_rise", 32'(rise0), 32'(er0));
        check_eq("f0_fall", 32'(fall0), 32'(ef0));
        check_eq("f4_sync", 32'(sync1), 32'(s1));
        check_eq("f4_rise", 32'(rise1), 32'(er1));
        check_eq("f4_fall", 32'(fall1), 32'(ef1));
`ifdef SYNC_EDGE_CNT_EN
        for (int i = 0; i < 4; i++) begin
            check_eq("f0_cnt", 32'(cnt0[i*2 +: 2]), 32'(ec0[i]));
            check_eq("f4_cnt", 32'(cnt1[i*2 +: 2]), 32'(ec1[i]));
        end
`endif
        for (int i = 0; i < 4; i++) begin
            if (fall0[i]) f0_fall[i]++;
            if (rise0[i]) f0_rise[i]++;
            if (rise1[i]) f4_rise[i]++;
            if (fall1[i]) f4_fall[i]++;
        end
    endtask

    initial begin
        int unsigned waited;
        clear_tallies();

        // reset held 3 cycles, inputs low
        rst_i = 1'b1; async_i = 4'b0000;
        repeat (3) step();
        check_eq("rst_sync_f0", 32'(sync0), 32'(4'b1010));

        // release: F=0 instance must fall on ch1/ch3 exactly once
        rst_i = 1'b0;
        clear_tallies();
        repeat (6) step();
        check_eq("rel_fall_ch1", f0_fall[1], 1);
        check_eq("rel_fall_ch3", f0_fall[3], 1);
        check_eq("rel_fall_ch0", f0_fall[0], 0);
        check_eq("rel_rise_any", f0_rise[0] + f0_rise[1] + f0_rise[2] + f0_rise[3], 0);

        // latency on ch0
        clear_tallies();
        async_i = 4'b0001;
        repeat (8) step();
        check_eq("lat_rise_ch0", f0_rise[0], 1);
        async_i = 4'b0000;
        repeat (8) step();

        // all channels at once
        clear_tallies();
        async_i = 4'b1111;
        repeat (8) step();
        async_i = 4'b0000;
        repeat (8) step();
        check_eq("multi_rise_ch2", f0_rise[2], 1);
        check_eq("multi_fall_ch3", f0_fall[3], 1);

        // glitch of 3 cycles on ch1 rejected by the filter
        clear_tallies();
        async_i = 4'b0010;
        repeat (3) step();
        async_i = 4'b0000;
        repeat (8) step();
        check_eq("glitch_rise_ch1", f4_rise[1], 0);
        check_eq("glitch_fall_ch1", f4_fall[1], 0);

        // 4-cycle pulse on ch1 passes
        clear_tallies();
        async_i = 4'b0010;
        repeat (4) step();
        async_i = 4'b0000;
        repeat (12) step();
        check_eq("pass4_rise_ch1", f4_rise[1], 1);

        // held high on ch2
        async_i = 4'b0100;
        repeat (9) step();
        check_eq("hold_sync_ch2", 32'(sync1[2]), 1);
        async_i = 4'b0000;
        repeat (9) step();

        // toggling ch3 restarts the filter count each return
        clear_tallies();
        repeat (4) begin
            async_i = 4'b1000; repeat (3) step();
            async_i = 4'b0000; step();
        end
        repeat (6) step();
        check_eq("toggle_rise_ch3", f4_rise[3], 0);

        // random levels held 1..6 cycles
        repeat (30) begin
            async_i = 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 6)) step();
        end

        // reset in the middle of a filter count
        async_i = 4'b0000;
        repeat (8) step();
        async_i = 4'b1111;
        repeat (4) step();
        rst_i = 1'b1;
        step();
        check_eq("midrst_sync_f4", 32'(sync1), 0);
        rst_i = 1'b0;
        async_i = 4'b0000;
        repeat (10) step();

`ifdef SYNC_EDGE_CNT_EN
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        repeat (5) begin
            async_i = 4'b0001; repeat (6) step();
            async_i = 4'b0000; repeat (6) step();
        end
        check_eq("cnt_sat_ch0", 32'(cnt0[1:0]), 3);
        // sixth rise with a coincident clear
        async_i = 4'b0001;
        waited = 0;
        while (!(s0[0] && !p0[0]) && waited < 12) begin
            step();
            waited++;
        end
        check_eq("clr_wait_ok", 32'(waited < 12), 1);
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        check_eq("cnt_clr_ch0", 32'(cnt0[1:0]), 0);
        async_i = 4'b0000;
        repeat (8) step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
